video_decimator: RTL
====================

# video_decimator

Parametrised integer video downscaler on the HDMI pixel-clock path, the generalised successor of the fixed 2:1 horizontal/vertical decimation used in the video processing top. Independently selectable horizontal and vertical reduction factors of 1, 2, 4 … 2^MAX_SHIFT, latched per frame. Optional horizontal box averaging replaces plain pixel dropping. Sits between the HDMI receiver stream and downstream scaling/frame-buffer logic; passes sync through with matched latency.

## Interface
- DATA_WIDTH, 24, pixel bus width; must equal RGB_R_WIDTH+RGB_G_WIDTH+RGB_B_WIDTH
- RGB_R_WIDTH, 8, red field, bits [DATA_WIDTH-1 -: RGB_R_WIDTH]
- RGB_G_WIDTH, 8, green field, middle bits
- RGB_B_WIDTH, 8, blue field, bits [RGB_B_WIDTH-1:0]
- MAX_SHIFT, 2, maximum log2 reduction factor (factor ≤ 4 by default)
- SW = clog2(MAX_SHIFT+1), derived local width of shift inputs

- clk  input  1  pixel clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- frame_i_vs  input  1  input vertical sync, active high
- frame_i_hs  input  1  input horizontal sync, active high
- frame_i_valid  input  1  input data enable
- frame_i_data  input  DATA_WIDTH  input pixel
- h_shift  input  SW  horizontal log2 factor; values > MAX_SHIFT saturate to MAX_SHIFT
- v_shift  input  SW  vertical log2 factor; same saturation
- frame_o_vs  output  1  frame_i_vs delayed 1 cycle
- frame_o_hs  output  1  frame_i_hs delayed 1 cycle
- frame_o_valid  output  1  kept/averaged pixel strobe
- frame_o_data  output  DATA_WIDTH  output pixel; 0 whenever frame_o_valid is 0

## Operation
- Edge detect: vs_rise = frame_i_vs & ~vs_d1; de_fall = ~frame_i_valid & de_d1 (vs_d1, de_d1 one-cycle registers).
- Shadow registers hs_q, vs_q load saturated h_shift/v_shift on vs_rise; reset value 0 (factor 1, pass-through).
- Pixel counter hcnt (MAX_SHIFT bits): cleared on vs_rise or de_fall; +1 per frame_i_valid, wraps at (1<<hs_q)-1.
- Line counter vcnt (MAX_SHIFT bits): cleared on vs_rise; +1 on de_fall, wraps at (1<<vs_q)-1. Line kept iff vcnt==0; first active line after vs_rise always kept.
- vs_rise coinciding with frame_i_valid: counters cleared, that pixel treated as hcnt=0/vcnt=0 of new frame; new shadows apply to it.
- Pure decimation (macro off): pixel kept iff frame_i_valid & line kept & hcnt==0.
- Trailing partial group (line width not multiple of factor): in decimation mode its first pixel is kept; in averaging mode it is discarded.
- Reset mid-line: all counters, shadows, accumulators, outputs to 0 immediately; resumes from next vs_rise-free data as factor 1 until next vs_rise.

## Timing
- All outputs registered; reset value 0 for frame_o_vs, frame_o_hs, frame_o_valid, frame_o_data.
- Latency: sync outputs 1 cycle; frame_o_valid/data 1 cycle after the qualifying input pixel (group's first pixel when decimating, last pixel when averaging).
- No backpressure; at most one output per input valid cycle. Output rate = input rate / 2^(hs_q+vs_q) per frame.
- hs_q=vs_q=0: output is exact 1-cycle-delayed copy of input stream.

## Configuration
- Macro DECIM_AVG_EN.
- Defined: per-channel accumulators of width RGB_x_WIDTH+MAX_SHIFT sum each group of 2^hs_q valid pixels on kept lines; on hcnt==(1<<hs_q)-1 output per channel acc>>hs_q (truncating), accumulator reloads with next pixel. Accumulators cleared on de_fall and vs_rise.
- Not defined: no accumulators synthesised; first pixel of each group forwarded unchanged.

## Test plan
- Reset held, random stimulus -> all outputs 0; release with 8-pixel line, shifts 0 -> outputs equal inputs delayed 1 cycle.
- h_shift=1, v_shift=1, 8x4 frame, pixel value = index 0..31 -> output 4x2 pixels 0,2,4,6,16,18,20,22 (decimation build).
- DECIM_AVG_EN, h_shift=2, line 0x000000,0x040404,0x080808,0x0C0C0C -> single output 0x060606 one cycle after 4th pixel.
- h_shift changed 1->2 mid-frame -> current frame still 2:1; change effective from next vs_rise.
- h_shift=2, 10-pixel line -> decimation: outputs at pixels 0,4,8; averaging: 2 outputs, trailing 2 pixels dropped.
- rst_n asserted mid-line with h_shift=2 latched -> outputs 0 instantly; after release output matches input 1:1 until next vs_rise.

Source files
------------

// File: rtl/video_decimator.sv
// video_decimator: power-of-two horizontal/vertical video downscaler with factors latched per frame.
// Define DECIM_AVG_EN to replace horizontal pixel dropping with box averaging.
module video_decimator #(
    parameter int  DATA_WIDTH  = 24,
    parameter int  RGB_R_WIDTH = 8,
    parameter int  RGB_G_WIDTH = 8,
    parameter int  RGB_B_WIDTH = 8,
    parameter int  MAX_SHIFT   = 2,
    localparam int SW          = $clog2(MAX_SHIFT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_i_vs,
    input  logic                  frame_i_hs,
    input  logic                  frame_i_valid,
    input  logic [DATA_WIDTH-1:0] frame_i_data,
    input  logic [SW-1:0]         h_shift,
    input  logic [SW-1:0]         v_shift,
    output logic                  frame_o_vs,
    output logic                  frame_o_hs,
    output logic                  frame_o_valid,
    output logic [DATA_WIDTH-1:0] frame_o_data
);

    localparam logic [SW-1:0]        MAX_SH  = SW'(MAX_SHIFT);
    localparam logic [MAX_SHIFT-1:0] CNT_ONE = MAX_SHIFT'(1);

    logic                  r_vs_d1;
    logic                  r_de_d1;
    logic [SW-1:0]         r_hs_q;
    logic [SW-1:0]         r_vs_q;
    logic [MAX_SHIFT-1:0]  r_hcnt;
    logic [MAX_SHIFT-1:0]  r_vcnt;
    logic                  r_o_vs;
    logic                  r_o_hs;
    logic                  r_o_valid;
    logic [DATA_WIDTH-1:0] r_o_data;

    logic                  w_vs_rise;
    logic                  w_de_fall;
    logic [SW-1:0]         w_h_sat;
    logic [SW-1:0]         w_v_sat;
    logic [SW-1:0]         w_hs_eff;
    logic [SW-1:0]         w_vs_eff;
    logic [MAX_SHIFT-1:0]  w_hmask;
    logic [MAX_SHIFT-1:0]  w_vmask;
    logic [MAX_SHIFT-1:0]  w_hcnt_cur;
    logic [MAX_SHIFT-1:0]  w_vcnt_cur;
    logic [MAX_SHIFT-1:0]  w_hcnt_inc;
    logic [MAX_SHIFT-1:0]  w_vcnt_inc;
    logic                  w_grp_first;
    logic                  w_grp_last;
    logic                  w_line_kept;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;

    assign w_vs_rise = frame_i_vs & ~r_vs_d1;
    assign w_de_fall = ~frame_i_valid & r_de_d1;

    assign w_h_sat = (h_shift > MAX_SH) ? MAX_SH : h_shift;
    assign w_v_sat = (v_shift > MAX_SH) ? MAX_SH : v_shift;

    // A pixel arriving together with the vsync edge already belongs to the new
    // frame, so it sees the freshly latched factors and cleared counters.
    assign w_hs_eff   = w_vs_rise ? w_h_sat : r_hs_q;
    assign w_vs_eff   = w_vs_rise ? w_v_sat : r_vs_q;
    assign w_hcnt_cur = w_vs_rise ? '0 : r_hcnt;
    assign w_vcnt_cur = w_vs_rise ? '0 : r_vcnt;

    // Wrap value (1<<shift)-1 built bit by bit: bit gi is set when shift > gi.
    for (genvar gi = 0; gi < MAX_SHIFT; gi++) begin : g_mask
        assign w_hmask[gi] = (w_hs_eff > SW'(gi));
        assign w_vmask[gi] = (w_vs_eff > SW'(gi));
    end

    assign w_grp_first = (w_hcnt_cur == '0);
    assign w_grp_last  = (w_hcnt_cur == w_hmask);
    assign w_line_kept = (w_vcnt_cur == '0);
    assign w_hcnt_inc  = w_grp_last ? '0 : (w_hcnt_cur + CNT_ONE);
    assign w_vcnt_inc  = (w_vcnt_cur == w_vmask) ? '0 : (w_vcnt_cur + CNT_ONE);

`ifdef DECIM_AVG_EN
    logic [DATA_WIDTH-1:0] w_avg_data;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        localparam int CW  = (gi == 0) ? RGB_R_WIDTH :
                             (gi == 1) ? RGB_G_WIDTH : RGB_B_WIDTH;
        localparam int LSB = (gi == 0) ? (RGB_G_WIDTH + RGB_B_WIDTH) :
                             (gi == 1) ? RGB_B_WIDTH : 0;
        localparam int AW  = CW + MAX_SHIFT;

        logic [AW-1:0] r_acc;
        logic [AW-1:0] w_sum;
        logic [CW-1:0] w_pix;

        assign w_pix = frame_i_data[LSB +: CW];
        // First pixel of a group restarts the sum, so no separate reload cycle is needed.
        assign w_sum = (w_grp_first ? '0 : r_acc) + {{MAX_SHIFT{1'b0}}, w_pix};
        assign w_avg_data[LSB +: CW] = CW'(w_sum >> w_hs_eff);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (w_de_fall) begin
                r_acc <= '0;
            end else if (frame_i_valid && w_line_kept) begin
                r_acc <= w_grp_last ? '0 : w_sum;
            end else if (w_vs_rise) begin
                r_acc <= '0;
            end
        end
    end

    assign w_out_valid = frame_i_valid & w_line_kept & w_grp_last;
    assign w_out_data  = w_avg_data;
`else
    assign w_out_valid = frame_i_valid & w_line_kept & w_grp_first;
    assign w_out_data  = frame_i_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d1   <= 1'b0;
            r_de_d1   <= 1'b0;
            r_hs_q    <= '0;
            r_vs_q    <= '0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_o_vs    <= 1'b0;
            r_o_hs    <= 1'b0;
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
        end else begin
            r_vs_d1 <= frame_i_vs;
            r_de_d1 <= frame_i_valid;

            if (w_vs_rise) begin
                r_hs_q <= w_h_sat;
                r_vs_q <= w_v_sat;
            end

            if (frame_i_valid) begin
                r_hcnt <= w_hcnt_inc;
            end else if (w_de_fall || w_vs_rise) begin
                r_hcnt <= '0;
            end

            // Frame start wins over a coincident line end so the first line is always kept.
            if (w_vs_rise) begin
                r_vcnt <= '0;
            end else if (w_de_fall) begin
                r_vcnt <= w_vcnt_inc;
            end

            r_o_vs    <= frame_i_vs;
            r_o_hs    <= frame_i_hs;
            r_o_valid <= w_out_valid;
            r_o_data  <= w_out_valid ? w_out_data : '0;
        end
    end

    assign frame_o_vs    = r_o_vs;
    assign frame_o_hs    = r_o_hs;
    assign frame_o_valid = r_o_valid;
    assign frame_o_data  = r_o_data;

endmodule
